// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side controller.
package uart_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ctrl_state_e;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int FIFO_DEPTH_DEF = fifo_depth(ADDR_W_DEF);

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the TX FIFO: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DBIT-1:0]   w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DBIT-1:0]   r_data
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DBIT-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; occupancy tracking makes stale contents unobservable.
  always_ff @(posedge clk) begin
    if (we) mem_q[w_addr] <= w_data;
  end

  assign r_data = mem_q[r_addr];

endmodule

// File: rtl/uart_tx_ctrl.sv
// TX buffer and launcher: queues bytes and pulses tx_start once per frame slot.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_data,
  input  logic              tx_done_tick
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              tx_start_q, tx_start_d;
  logic [DBIT-1:0]   tx_data_q, tx_data_d;

  logic            wr_accept;
  logic            pop;
  logic [DBIT-1:0] rd_data;

  uart_fifo_mem #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .we     (wr_accept),
    .w_addr (wr_ptr_q),
    .w_data (w_data),
    .r_addr (rd_ptr_q),
    .r_data (rd_data)
  );

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  assign wr_accept = wr && !full;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d    = state_q;
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (tx_done_tick) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      tx_start_d = 1'b1;
      tx_data_d  = rd_data;
    end

    wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q || (wr && full);

    count_d = count_q;
    if (wr_accept && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !wr_accept) count_d = count_q - CNT_ONE;
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: queue-based reference model plus a launch monitor.
module tb_uart_tx_ctrl;

  localparam int DBIT   = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr = 1'b0;
  logic [DBIT-1:0]   w_data = '0;
  logic              tx_done_tick = 1'b0;
  logic              full, empty, overflow, tx_start;
  logic [ADDR_W:0]   count;
  logic [DBIT-1:0]   tx_data;

  uart_tx_ctrl #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bytes waiting in the FIFO, whether a frame is in flight, sticky overflow.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_busy = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_start = 1'b0;
  logic [7:0] m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit done, input bit rst_n);
    bit was_full, was_empty, launch;
    if (!rst_n) begin
      model_q.delete();
      m_busy  = 1'b0;
      m_ovf   = 1'b0;
      m_start = 1'b0;
      m_data  = '0;
      return;
    end
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    launch    = 1'b0;
    if (!m_busy && !was_empty)     launch = 1'b1;
    else if (m_busy && done) begin
      if (!was_empty) launch = 1'b1;
      else            m_busy = 1'b0;
    end
    if (launch) begin
      m_data = model_q.pop_front();
      exp_q.push_back(m_data);
      m_busy = 1'b1;
    end
    if (w) begin
      if (was_full) m_ovf = 1'b1;
      else          model_q.push_back(d);
    end
    m_start = launch;
  endtask

  // One clock: drive at negedge, model at posedge, compare registered outputs at next negedge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit done, input bit rst_n);
    wr = w; w_data = d; tx_done_tick = done; reset = rst_n;
    @(posedge clk);
    model_step(w, d, done, rst_n);
    @(negedge clk);
    check("count",    32'(count),    32'(model_q.size()));
    check("empty",    32'(empty),    32'(model_q.size() == 0));
    check("full",     32'(full),     32'(model_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_start", 32'(tx_start), 32'(m_start));
    check("tx_data",  32'(tx_data),  32'(m_data));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic put(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic done_tick();
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  // Monitor: every launch must match the next byte the model expected to leave the FIFO.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("launch_unexpected", 32'(tx_start), 32'd0);
      end else begin
        check("launch_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset, then quiet idle.
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    idle(20);

    // Single byte, long frame, then done returns to idle.
    put(8'hA5);
    check("single_pending", 32'(empty), 32'd0);
    idle(1);
    check("single_start", 32'(tx_start), 32'd1);
    check("single_data",  32'(tx_data),  32'hA5);
    idle(99);
    done_tick();
    idle(5);

    // Back-to-back frames.
    put(8'h11); put(8'h22); put(8'h33);
    for (int f = 0; f < 3; f++) begin
      idle(4);
      done_tick();
      check("b2b_start", 32'(tx_start), 32'(f < 2));
    end
    idle(3);

    // Fill while busy, overflow on the 17th write, then drain.
    put(8'hEE);
    idle(2);
    for (int i = 0; i < 16; i++) put(8'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    put(8'h10);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd16);
    for (int i = 0; i < 17; i++) begin
      done_tick();
      idle(2);
    end
    check("drain_empty", 32'(empty),    32'd1);
    check("ovf_sticky",  32'(overflow), 32'd1);

    // Simultaneous accepted write and pop keeps count steady.
    for (int i = 0; i < 6; i++) put(8'h40 + 8'(i));
    idle(1);
    check("simul_pre", 32'(count), 32'd5);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    check("simul_count", 32'(count),    32'd5);
    check("simul_start", 32'(tx_start), 32'd1);
    for (int i = 0; i < 6; i++) begin
      done_tick();
      idle(1);
    end
    done_tick();
    check("spurious_idle", 32'(tx_start), 32'd0);
    idle(3);

    // Reset mid-operation discards queue and in-flight frame.
    for (int i = 0; i < 4; i++) put(8'hC0 + 8'(i));
    idle(1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("midrst_count", 32'(count),    32'd0);
    check("midrst_start", 32'(tx_start), 32'd0);
    check("midrst_ovf",   32'(overflow), 32'd0);
    done_tick();
    check("midrst_no_launch", 32'(tx_start), 32'd0);
    idle(3);

    // Randomised traffic with occasional reset and spurious done pulses.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 1) == 1), 8'($urandom()),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 299) != 0));
    end
    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
